// File: rtl/data_mem_pipe.sv
// data_mem_pipe: word-organised data RAM with byte-addressed valid/ready
// requests, per-byte write enables, LATENCY-deep response pipeline and an
// error flag for misaligned or out-of-range accesses.
module data_mem_pipe #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 256,
   parameter int ADDR_W       = 32,
   parameter int LATENCY      = 1,
   parameter int INIT_PATTERN = 1
)(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err
);
   localparam int NB    = DATA_W / 8;
   localparam int OFF   = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);

   // byte-offset bits must be zero; any bit above the word index is out of range
   localparam logic [ADDR_W-1:0] ONE     = 1;
   localparam logic [ADDR_W-1:0] LO_MASK = (ONE << OFF) - ONE;
   localparam logic [ADDR_W-1:0] HI_MASK = ~((ONE << (OFF + IDX_W)) - ONE);

   typedef struct packed {
      logic              write;
      logic              err;
      logic [DATA_W-1:0] rdata;
   } stage_t;

   typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

   function automatic mem_t init_mem();
      mem_t m;
      for (int i = 0; i < DEPTH; i++)
         m[i] = (INIT_PATTERN == 1) ? DATA_W'(i) : '0;
      return m;
   endfunction

   // contents are loaded once at time zero and never touched by reset
   mem_t mem = init_mem();

   logic [IDX_W-1:0]     idx;
   logic                 acc_err;
   logic                 stall;
   logic                 acc;
   stage_t               stg_in;
   logic [LATENCY:1]     vld_q;
   stage_t [LATENCY:1]   stg_q;
   logic [LATENCY:0]     vld_pipe;
   stage_t [LATENCY:0]   stg;

   assign idx      = req_addr[OFF +: IDX_W];
   assign acc_err  = (|(req_addr & LO_MASK)) | (|(req_addr & HI_MASK));
   assign stall    = vld_pipe[LATENCY] && !resp_ready;
   assign req_ready = reset_n && !stall;
   assign acc      = req_valid && req_ready;

   // stage 0 is the request being accepted this cycle; later stages are registers
   assign vld_pipe = {vld_q, acc};
   assign stg      = {stg_q, stg_in};

   // build the stage-0 payload; reads see every write committed on earlier edges
   always_comb begin
      stg_in = '0;
      if (acc) begin
         stg_in.write = req_write;
         stg_in.err   = acc_err;
         stg_in.rdata = (req_write || acc_err) ? '0 : mem[idx];
      end
   end

   // commit enabled bytes of a legal write at the acceptance edge
   always_ff @(posedge clock) begin
      if (acc && req_write && !acc_err) begin
         for (int k = 0; k < NB; k++)
            if (req_be[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
   end

   // response shift register; a stalled output freezes every stage, bubbles included
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         stg_q <= '0;
      end else if (!stall) begin
         for (int s = 1; s <= LATENCY; s++) begin
            vld_q[s] <= vld_pipe[s-1];
            stg_q[s] <= stg[s-1];
         end
      end
   end

   assign resp_valid = vld_pipe[LATENCY];
   assign resp_err   = stg[LATENCY].err;
   // write responses never carry data, even if a payload bit were set
   assign resp_rdata = stg[LATENCY].write ? '0 : stg[LATENCY].rdata;

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: table of requests with expected responses driven through
// a scoreboard queue, plus hand-written stall and mid-flight reset sequences.
module tb_data_mem_pipe;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int LAT = 2;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_write = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic [DW-1:0]   req_wdata = '0;
   logic [DW/8-1:0] req_be = '0;
   logic            resp_valid;
   logic            resp_ready = 1'b1;
   logic [DW-1:0]   resp_rdata;
   logic            resp_err;

   data_mem_pipe #(
      .DATA_W(DW), .DEPTH(256), .ADDR_W(AW), .LATENCY(LAT), .INIT_PATTERN(1)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            due;
   } exp_t;

   typedef struct {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [3:0]    be;
      logic [DW-1:0] er;
      logic          ee;
   } vec_t;

   exp_t          sbq[$];
   int            total = 0;
   int            bad = 0;
   logic          chk_lat = 1'b1;
   logic [DW-1:0] nxt_rdata = '0;
   logic          nxt_err = 1'b0;

   // pop and compare delivered responses, then queue the request accepted this cycle
   always @(negedge clock) begin
      exp_t e;
      if (reset_n && resp_valid && resp_ready) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp got rdata=%h err=%0b want none", resp_rdata, resp_err);
         end else begin
            e = sbq.pop_front();
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
               bad++;
               $display("FAIL resp_data got rdata=%h err=%0b want rdata=%h err=%0b",
                        resp_rdata, resp_err, e.rdata, e.err);
            end
            if (e.due >= 0) begin
               total++;
               if (cyc != e.due) begin
                  bad++;
                  $display("FAIL resp_latency got cycle=%0d want cycle=%0d", cyc, e.due);
               end
            end
         end
      end
      if (reset_n && req_valid && req_ready)
         sbq.push_back('{rdata: nxt_rdata, err: nxt_err, due: (chk_lat ? cyc + LAT : -1)});
   end

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // drive one request and hold it until accepted; returns 1 time unit after the accepting edge
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] be, input logic [DW-1:0] er, input logic ee);
      int n = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      nxt_rdata = er; nxt_err = ee;
      @(negedge clock);
      while (!req_ready && n < 20) begin
         n++;
         @(negedge clock);
      end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout addr=%h got req_ready=0 want 1", a);
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 30) begin
         n++;
         @(negedge clock);
      end
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout got pending=%0d want 0", sbq.size());
      end
      @(posedge clock); #1;
   endtask

   initial begin
      vec_t vt[$];
      vt.push_back('{1'b0, 32'h28,  32'h0,        4'h0, 32'h0000000A, 1'b0});
      vt.push_back('{1'b1, 32'h40,  32'hDEADBEEF, 4'b0101, 32'h0,     1'b0});
      vt.push_back('{1'b0, 32'h40,  32'h0,        4'h0, 32'h00AD00EF, 1'b0});
      vt.push_back('{1'b0, 32'h41,  32'h0,        4'h0, 32'h0,        1'b1});
      vt.push_back('{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1});
      vt.push_back('{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
      vt.push_back('{1'b0, 32'h0,   32'h0,        4'h0, 32'h0,        1'b0});
      vt.push_back('{1'b0, 32'h0,   32'h0,        4'h0, 32'h0,        1'b0});
      vt.push_back('{1'b0, 32'h4,   32'h0,        4'h0, 32'h1,        1'b0});
      vt.push_back('{1'b0, 32'h8,   32'h0,        4'h0, 32'h2,        1'b0});
      vt.push_back('{1'b0, 32'hC,   32'h0,        4'h0, 32'h3,        1'b0});
      vt.push_back('{1'b1, 32'h44,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0});
      vt.push_back('{1'b0, 32'h44,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0});
      vt.push_back('{1'b1, 32'h48,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
      vt.push_back('{1'b0, 32'h48,  32'h0,        4'h0, 32'h00000012, 1'b0});
      vt.push_back('{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h000000FF, 1'b0});
      vt.push_back('{1'b0, 32'h80000000, 32'h0,   4'h0, 32'h0,        1'b1});
      vt.push_back('{1'b0, 32'h2,   32'h0,        4'h0, 32'h0,        1'b1});

      // reset state
      @(negedge clock);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err",   {31'd0, resp_err},   32'h0);
      check("rst_req_ready",  {31'd0, req_ready},  32'h0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;

      // table: issued back to back, each response due exactly LAT cycles later
      for (int i = 0; i < vt.size(); i++)
         send(vt[i].w, vt[i].a, vt[i].d, vt[i].be, vt[i].er, vt[i].ee);
      drain();

      // back-pressure: two responses queued, consumer stalls for 3 cycles
      chk_lat = 1'b0;
      resp_ready = 1'b0;
      send(1'b0, 32'h10, 32'h0, 4'h0, 32'h4, 1'b0);
      send(1'b0, 32'h14, 32'h0, 4'h0, 32'h5, 1'b0);
      begin
         int n = 0;
         while (!resp_valid && n < 10) begin
            n++;
            @(negedge clock);
         end
      end
      for (int i = 0; i < 3; i++) begin
         check("stall_req_ready",  {31'd0, req_ready},  32'h0);
         check("stall_resp_valid", {31'd0, resp_valid}, 32'h1);
         check("stall_resp_rdata", resp_rdata, 32'h4);
         @(negedge clock);
      end
      @(posedge clock); #1;
      resp_ready = 1'b1;
      drain();
      chk_lat = 1'b1;

      // reset while a write response is still in flight
      send(1'b1, 32'h8, 32'h12345678, 4'hF, 32'h0, 1'b0);
      reset_n = 1'b0;
      sbq.delete();
      @(negedge clock);
      check("midrst_resp_valid", {31'd0, resp_valid}, 32'h0);
      check("midrst_req_ready",  {31'd0, req_ready},  32'h0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("postrst_no_resp", {31'd0, resp_valid}, 32'h0);
      end
      @(posedge clock); #1;
      send(1'b0, 32'h8, 32'h0, 4'h0, 32'h12345678, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised RAM with byte-addressed requests, per-byte write enables and configurable read latency.
- Valid/ready request and response handshakes with response back-pressure.
- Error flag for misaligned or out-of-range accesses; sits between the MEM stage and the core/bus fabric.

Parameters:
- DATA_W, 32, data word width in bits; multiple of 8, at least 8.
- DEPTH, 256, number of words; power of two.
- ADDR_W, 32, request byte-address width.
- LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..4.
- INIT_PATTERN, 1, when 1 word i is initialised to value i at time zero; when 0 all words initialise to 0.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables; bit k covers bits [8k+7:8k].
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  DATA_W  read data; 0 for writes and errors.
- resp_err  output  1  access was misaligned or out of range.

Behaviour:
- Clock/reset: one clock, rising edge only. reset_n is asynchronous and active-low.
- While reset_n is low: resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0, all pipeline valid bits cleared. Memory contents are NOT affected by reset.
- Addressing:
  - OFF = log2(DATA_W/8), IDX_W = log2(DEPTH).
  - Word index = req_addr[OFF+IDX_W-1:OFF].
  - Misaligned: req_addr[OFF-1:0] != 0 (never for DATA_W=8).
  - Out of range: any req_addr bit at or above OFF+IDX_W is set.
  - Either condition: no memory write, response carries resp_err=1 and resp_rdata=0.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready.
  - stall = resp_valid && !resp_ready.
  - req_ready = reset_n && !stall.
- Writes:
  - Committed at the acceptance edge, for bytes with req_be=1 only; other bytes keep their old value.
  - req_be all-zero is a legal no-op write: response still issued, err=0.
- Reads: sample the memory at the acceptance edge (post-write state of earlier requests).
  - A read accepted the cycle after a write to the same word returns the new data.
- Every accepted request, read or write, produces exactly one response, in order.
- Pipeline:
  - LATENCY-stage shift register of {valid, write, err, rdata}.
  - With no stall, resp_valid rises exactly LATENCY cycles after the acceptance edge.
  - Back-to-back requests give one response per cycle (throughput 1).
- Stall:
  - When stall=1, all stages hold, no request is accepted, and resp_* stay stable until resp_ready.
  - Bubbles do not collapse during a stall (simple freeze).
- Response fields: a write response has resp_rdata=0. An error response has resp_rdata=0 and resp_err=1.
- Reset mid-operation: in-flight responses are discarded. Writes already committed remain in memory.
- Unaccepted requests have no side effects.
- Initialisation: per INIT_PATTERN, applied once at time zero. Values wider than DATA_W are truncated.

Test Plan (DATA_W=32, DEPTH=256, LATENCY=2, INIT_PATTERN=1, resp_ready=1 unless stated):
- Reset then read at address 0x28 -> resp_valid 2 cycles after acceptance, resp_rdata=0x0000000A, resp_err=0.
- Write 0xDEADBEEF at 0x40 with be=4'b0101, then read 0x40 the next cycle -> write response (rdata=0, err=0), then read response rdata=0x00AD00EF (old word 0x10: bytes 3,1 unchanged).
- Read at 0x41 -> err=1, rdata=0. Read at 0x400 -> err=1, rdata=0. Write at 0x400 -> err=1, and a subsequent read of 0x0 still returns 0x0.
- Issue 4 back-to-back reads of 0x0,0x4,0x8,0xC -> 4 consecutive resp_valid cycles with rdata 0,1,2,3 in order.
- Hold resp_ready=0 for 3 cycles while 2 responses are queued -> req_ready=0 and resp_rdata stable throughout. After release, both responses are delivered in order with none lost or duplicated.
- Accept a write of 0x12345678 at 0x8 (be=4'hF), then assert reset_n=0 before its response -> no response after reset, and a later read of 0x8 returns 0x12345678.
